// File: rtl/butterfly_net_256_pipe.sv
// Pipelined forward butterfly network over a 256-bit word.
// Eight swap stages (distance 128 down to 1) split into register slices of
// STAGES_PER_REG stages each, connected by a valid/ready elastic pipeline.
// Per-stage selector words live in local registers and may only change
// while the pipeline is empty, so every item sees one consistent config set.
module butterfly_net_256_pipe #(
  parameter int unsigned STAGES_PER_REG = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_we,
  input  logic [2:0]   cfg_idx,
  input  logic [127:0] cfg_wdata,
  output logic         cfg_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_data
);

  localparam int unsigned DATA_W     = 256;
  localparam int unsigned CFG_W      = 128;
  localparam int unsigned NUM_STAGES = 8;
  localparam int unsigned NSLICE     = NUM_STAGES / STAGES_PER_REG;

  // One swap stage: pair p maps to (lo, lo + d) where lo keeps the low
  // log2(d) bits of p and shifts the remaining bits up past the d bit.
  function automatic logic [DATA_W-1:0] bfly_stage(
    input logic [DATA_W-1:0] x,
    input logic [CFG_W-1:0]  sel,
    input logic [2:0]        s
  );
    logic [DATA_W-1:0] y;
    logic [7:0]        dd;
    logic [7:0]        mask;
    logic [7:0]        pp;
    logic [7:0]        lo;
    logic [7:0]        hi;
    y    = x;
    dd   = 8'd128 >> s;
    mask = dd - 8'd1;
    for (int p = 0; p < int'(CFG_W); p++) begin
      pp = 8'(p);
      lo = ((pp & ~mask) << 1) | (pp & mask);
      hi = lo | dd;
      if (sel[pp[6:0]]) begin
        y[lo] = x[hi];
        y[hi] = x[lo];
      end
    end
    return y;
  endfunction

  logic [NUM_STAGES-1:0][CFG_W-1:0] cfg_q;
  logic [NSLICE-1:0]                vld_q;
  logic [NSLICE-1:0]                vld_d;
  logic [NSLICE-1:0][DATA_W-1:0]    dat_q;
  logic [NSLICE-1:0][DATA_W-1:0]    dat_d;
  logic [NSLICE-1:0]                load_c;
  logic                             accept_c;
  logic                             cfg_wr_c;

  // Input side is blocked by a pending config write; config side waits for
  // an empty pipeline and no offered data, so the two never interleave.
  assign in_ready  = load_c[0] & ~cfg_we;
  assign accept_c  = in_valid & in_ready;
  assign cfg_ready = ~(|vld_q) & ~in_valid;
  assign cfg_wr_c  = cfg_we & cfg_ready;

  assign out_valid = vld_q[NSLICE-1];
  assign out_data  = dat_q[NSLICE-1];

  for (genvar k = 0; k < int'(NSLICE); k++) begin : g_slice
    logic              src_vld_c;
    logic [DATA_W-1:0] src_dat_c;
    logic [DATA_W-1:0] stg_c;

    // A slice can load if it or any slice downstream of it is empty, or the
    // consumer is taking the head item this cycle.
    assign load_c[k] = out_ready | ~(&vld_q[NSLICE-1:k]);

    if (k == 0) begin : g_head
      assign src_vld_c = accept_c;
      assign src_dat_c = in_data;
    end else begin : g_body
      assign src_vld_c = vld_q[k-1];
      assign src_dat_c = dat_q[k-1];
    end

    // Apply this slice's group of swap stages in increasing stage order.
    always_comb begin
      logic [2:0] sidx;
      sidx  = '0;
      stg_c = src_dat_c;
      for (int unsigned i = 0; i < STAGES_PER_REG; i++) begin
        sidx  = 3'(k * STAGES_PER_REG + i);
        stg_c = bfly_stage(stg_c, cfg_q[sidx], sidx);
      end
    end

    assign vld_d[k] = load_c[k] ? src_vld_c : vld_q[k];
    assign dat_d[k] = load_c[k] ? stg_c     : dat_q[k];
  end

  // Per-stage selector registers; reset to identity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else if (cfg_wr_c) begin
      cfg_q[cfg_idx] <= cfg_wdata;
    end
  end

  // Pipeline slice registers (valid + data).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: tb/tb_butterfly_net_256_pipe.sv
// Bench for butterfly_net_256_pipe: scoreboard of bit-level reference results,
// one task per scenario.
module tb_butterfly_net_256_pipe;

  localparam int unsigned SPR = 2;
  localparam int          L   = 8 / int'(SPR);

  logic         clk;
  logic         rst_n;
  logic         cfg_we;
  logic [2:0]   cfg_idx;
  logic [127:0] cfg_wdata;
  logic         cfg_ready;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_data;

  int checks = 0;
  int errors = 0;

  logic [127:0] tb_cfg [8];
  logic [255:0] exp_q [$];
  logic [255:0] got_q [$];

  butterfly_net_256_pipe #(.STAGES_PER_REG(SPR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_wdata (cfg_wdata),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference stage: walk j upward, number the pairs as they appear.
  function automatic logic [255:0] stage_ref(input logic [255:0] x, input logic [127:0] c, input int s);
    logic [255:0] y;
    int d;
    int p;
    y = x;
    d = 128 >> s;
    p = 0;
    for (int j = 0; j < 256; j++) begin
      if ((j & d) == 0) begin
        if (c[7'(p)]) begin
          y[8'(j)]     = x[8'(j + d)];
          y[8'(j + d)] = x[8'(j)];
        end
        p++;
      end
    end
    return y;
  endfunction

  function automatic logic [255:0] fwd_model(input logic [255:0] x);
    logic [255:0] v;
    v = x;
    for (int s = 0; s < 8; s++) v = stage_ref(v, tb_cfg[3'(s)], s);
    return v;
  endfunction

  function automatic logic [255:0] inv_model(input logic [255:0] x);
    logic [255:0] v;
    v = x;
    for (int s = 7; s >= 0; s--) v = stage_ref(v, tb_cfg[3'(s)], s);
    return v;
  endfunction

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Record accepted inputs (as reference results) and delivered outputs.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(fwd_model(in_data));
      if (out_valid && out_ready) got_q.push_back(out_data);
    end
  end

  task automatic send(input logic [255:0] d, output bit ok, output int waits);
    bit rdy;
    in_valid = 1'b1;
    in_data  = d;
    ok       = 1'b0;
    waits    = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    in_valid = 1'b0;
  endtask

  task automatic write_cfg(input logic [2:0] idx, input logic [127:0] d, output bit ok);
    bit rdy;
    cfg_we    = 1'b1;
    cfg_idx   = idx;
    cfg_wdata = d;
    ok        = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rdy = cfg_ready;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    cfg_we = 1'b0;
    if (ok) tb_cfg[idx] = d;
  endtask

  task automatic wait_drain(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (got_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (out_data !== 256'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_identity_latency();
    logic [255:0] pat;
    bit ok;
    int w;
    pat = {4{64'h0123456789ABCDEF}};
    clear_sb();
    send(pat, ok, w);
    checks++;
    if (!ok) begin errors++; $display("FAIL ident_accept got timeout want accept"); end
    for (int c = 0; c <= L + 1; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'(c == L - 1)) begin
        errors++;
        $display("FAIL ident_latency cycle %0d got out_valid %b want %b", c, out_valid, (c == L - 1));
      end
      if (c == L - 1) begin
        checks++;
        if (out_data !== pat) begin errors++; $display("FAIL ident_data got %h want %h", out_data, pat); end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      errors++;
      $display("FAIL ident_count got %0d outputs want 1 (inputs %0d)", got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_half_swap();
    logic [255:0] din;
    logic [255:0] want;
    bit ok;
    int w;
    din  = {{8{16'hAAAA}}, {8{16'h5555}}};
    want = {{8{16'h5555}}, {8{16'hAAAA}}};
    write_cfg(3'd0, '1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL half_cfg_write got timeout want accept"); end
    clear_sb();
    send(din, ok, w);
    wait_drain(1, ok);
    checks++;
    if (!ok || got_q.size() != 1) begin
      errors++;
      $display("FAIL half_count got %0d outputs want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== want) begin errors++; $display("FAIL half_data got %h want %h", got_q[0], want); end
      checks++;
      if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL half_model got %h want %h", got_q[0], exp_q[0]); end
    end
    write_cfg(3'd0, '0, ok);
  endtask

  task automatic test_last_stage();
    bit ok;
    int w;
    write_cfg(3'd7, '1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL last_cfg_write got timeout want accept"); end
    clear_sb();
    send(256'h1, ok, w);
    send(256'h3, ok, w);
    wait_drain(2, ok);
    checks++;
    if (!ok || got_q.size() != 2) begin
      errors++;
      $display("FAIL last_count got %0d outputs want 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 256'h2) begin errors++; $display("FAIL last_one got %h want 2", got_q[0]); end
      checks++;
      if (got_q[1] !== 256'h3) begin errors++; $display("FAIL last_three got %h want 3", got_q[1]); end
    end
    write_cfg(3'd7, '0, ok);
  endtask

  task automatic test_round_trip();
    logic [255:0] orig_q [$];
    logic [255:0] orig;
    bit ok;
    int w;
    int stalls;
    int bad_cfg;
    int bad_acc;
    bad_cfg = 0;
    bad_acc = 0;
    stalls  = 0;
    for (int s = 0; s < 8; s++) begin
      write_cfg(3'(s), {$urandom, $urandom, $urandom, $urandom}, ok);
      if (!ok) bad_cfg++;
    end
    checks++;
    if (bad_cfg != 0) begin errors++; $display("FAIL rt_cfg_write got %0d timeouts want 0", bad_cfg); end
    clear_sb();
    out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      orig = rand256();
      orig_q.push_back(orig);
      send(inv_model(orig), ok, w);
      if (!ok) bad_acc++;
      stalls += w;
    end
    checks++;
    if (bad_acc != 0 || stalls != 0) begin
      errors++;
      $display("FAIL rt_throughput got %0d stall cycles %0d timeouts want 0 0", stalls, bad_acc);
    end
    wait_drain(1000, ok);
    checks++;
    if (!ok || got_q.size() != 1000 || exp_q.size() != 1000) begin
      errors++;
      $display("FAIL rt_count got %0d outputs want 1000", got_q.size());
    end else begin
      for (int i = 0; i < 1000; i++) begin
        checks++;
        if (got_q[i] !== orig_q[i]) begin
          errors++;
          $display("FAIL rt_inverse item %0d got %h want %h", i, got_q[i], orig_q[i]);
        end
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rt_model item %0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [255:0] prev_data;
    bit prev_stall;
    bit drv_done;
    bit ok;
    int bad_acc;
    drv_done = 1'b0;
    bad_acc  = 0;
    clear_sb();
    fork
      begin
        int w;
        bit aok;
        for (int i = 0; i < 20; i++) begin
          send(rand256(), aok, w);
          if (!aok) bad_acc++;
        end
        drv_done = 1'b1;
      end
      begin
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
          @(negedge clk);
          if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data) begin
              errors++;
              $display("FAIL stall_hold got %b/%h want 1/%h", out_valid, out_data, prev_data);
            end
          end
          prev_stall = out_valid && !out_ready;
          prev_data  = out_data;
          if (drv_done && got_q.size() >= 20) break;
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(20, ok);
    repeat (L + 2) @(posedge clk);
    #1;
    checks++;
    if (bad_acc != 0 || got_q.size() != 20 || exp_q.size() != 20) begin
      errors++;
      $display("FAIL bp_count got %0d outputs %0d inputs %0d timeouts want 20 20 0",
               got_q.size(), exp_q.size(), bad_acc);
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bp_order item %0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_cfg_inflight();
    logic [127:0] wd;
    bit ok;
    bit rdy;
    int w;
    wd = {$urandom, $urandom, $urandom, $urandom};
    clear_sb();
    out_ready = 1'b0;
    send(rand256(), ok, w);
    send(rand256(), ok, w);
    cfg_we    = 1'b1;
    cfg_idx   = 3'd3;
    cfg_wdata = wd;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (cfg_ready !== 1'b0) begin errors++; $display("FAIL inflight_cfg_ready got %b want 0", cfg_ready); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL inflight_in_ready got %b want 0", in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      rdy = cfg_ready;
      @(posedge clk); #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    cfg_we = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL inflight_cfg_accept got timeout want accept after drain"); end
    else tb_cfg[3] = wd;
    send(rand256(), ok, w);
    wait_drain(3, ok);
    checks++;
    if (!ok || got_q.size() != 3) begin
      errors++;
      $display("FAIL inflight_count got %0d outputs want 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL inflight_data item %0d got %h want %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    in_valid = 1'b1;
    in_data  = rand256();
    cfg_we   = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || cfg_ready !== 1'b0) begin
      errors++;
      $display("FAIL both_req got in_ready %b cfg_ready %b want 0 0", in_ready, cfg_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_inflight();
    logic [255:0] pat;
    bit ok;
    int w;
    clear_sb();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand256(), ok, w);
    repeat (L) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b want 1", out_valid); end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 256'h0) begin
      errors++;
      $display("FAIL rst_async got %b/%h want 0/0", out_valid, out_data);
    end
    clear_sb();
    for (int s = 0; s < 8; s++) tb_cfg[s] = '0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale cycle %0d got out_valid %b want 0", c, out_valid); end
    end
    @(posedge clk); #1;
    pat = rand256();
    send(pat, ok, w);
    wait_drain(1, ok);
    checks++;
    if (!ok || got_q.size() != 1) begin
      errors++;
      $display("FAIL rst_post_count got %0d outputs want 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== pat) begin errors++; $display("FAIL rst_post_identity got %h want %h", got_q[0], pat); end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cfg_we    = 1'b0;
    cfg_idx   = '0;
    cfg_wdata = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int s = 0; s < 8; s++) tb_cfg[s] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_identity_latency();
    test_half_swap();
    test_last_stage();
    test_round_trip();
    test_back_to_back_stall();
    test_cfg_inflight();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/butterfly_net_256_pipe.md
Name: butterfly_net_256_pipe

Overview:
Pipelined forward butterfly network, 256-bit datapath, 8 swap stages with distances 128, 64, 32, 16, 8, 4, 2, 1. It is the inverse-direction partner of the inverse-butterfly unit in the bit-manipulation path, used for the scatter/deposit side of grp/pdep-style permutations. It holds the per-stage config words in internal registers and moves data through a valid/ready elastic pipeline.

Parameters:
STAGES_PER_REG, 2, swap stages per pipeline register slice; legal values 1, 2, 4, 8; latency L = 8/STAGES_PER_REG cycles

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  config write strobe
cfg_idx  in  3  stage index s to write (s=0 is distance 128, s=7 is distance 1)
cfg_wdata  in  128  config word for stage s
cfg_ready  out  1  config write accepted this cycle when high
in_valid  in  1  input data valid
in_ready  out  1  input accepted when in_valid && in_ready
in_data  in  256  data to permute
out_valid  out  1  output data valid
out_ready  in  1  downstream accepts
out_data  out  256  permuted data

Behaviour:
- Stage s, distance d=128>>s: pairs (j, j+d) for every j with (j & d)==0, enumerated by increasing j as p=0..127. Selector is cfg_s[p]. cfg_s[p]=0 passes through (out[j]=in[j], out[j+d]=in[j+d]); cfg_s[p]=1 swaps the two bits.
- Stage order is s=0 through s=7. For identical per-distance config words, the block is the exact inverse of the inverse-butterfly network.
- Pipeline: one register slice after every STAGES_PER_REG stages. Each slice holds data plus a valid bit. The last slice drives out_data/out_valid directly, with no combinational path from in_data to out_data.
- Elastic rule per slice k: the slice loads when its valid is 0, or when slice k+1 loads (the last slice loads when out_ready is 1). Full throughput: one item per cycle under continuous out_ready.
- in_ready = first slice can load AND NOT cfg_we. in_ready combinationally depends on out_ready through the ready chain.
- Latency: an item accepted at edge t has out_valid=1 after edge t+L-1 (visible in cycle t+L), assuming no stall.
- Stall: while out_valid && !out_ready, out_data and out_valid hold stable. Upstream slices fill up, then in_ready drops to 0. No item is lost or duplicated.
- Config: the cfg regs are 8x128 bits, reset to 0 (identity). cfg_ready = all slice valids 0 AND NOT in_valid.
- A write occurs when cfg_we && cfg_ready; cfg_s <= cfg_wdata at that edge. If cfg_we is high while cfg_ready=0, the write is ignored, and the writer holds cfg_we until accepted.
- If cfg_we and in_valid are high together, in_ready is forced to 0 and cfg_ready is 0 (in_valid is high). This is a deadlock-free rule: the writer must drop in_valid first; data never observes a partially updated config.
- Config reads are live. Because writes occur only when the pipeline is empty, every item sees one consistent config set.
- Reset (async assert, sync deassert assumed by top level): all slice valids=0, out_valid=0, out_data=0, cfg regs=0. After reset, in_ready=1 and cfg_ready=1 (with in_valid=0, cfg_we=0). Mid-operation reset drops all in-flight items; no output for them after release.
- cfg_idx is 3 bits, so every value 0..7 is legal; there is no out-of-range case.

Test Plan:
- After reset, all cfg=0; in_data=256'h0123...CDEF random pattern -> out_data equals in_data exactly L cycles later; out_valid pulses once.
- Write cfg0=all ones, others 0; in_data={128'hAAAA...,128'h5555...} -> out_data={128'h5555...,128'hAAAA...} (halves swapped).
- Write cfg7=all ones only; in_data=256'h1 -> out_data=256'h2; in_data=256'h3 -> out_data=256'h3.
- Round-trip: random cfg per distance, 1000 random words through the inverse-butterfly model then this block -> output equals original; also check against a bit-level reference model.
- Backpressure: stream 20 items, out_ready toggles 1/0 randomly -> order preserved, no drops or duplicates, out_data stable during stall, throughput 1/cycle when out_ready=1.
- cfg_we while 2 items are in flight -> cfg_ready=0, write ignored until drain, then accepted. Assert rst_n=0 with 3 items in flight -> out_valid=0 immediately and no stale output after release.
